// File: rtl/multicycle_pkg.sv
// Shared state, opcode, funct and ALU encodings for the multicycle controller.
// Optional macro MULTICYCLE_BNE_EN adds the BNE state and the BranchNe control.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
`ifdef MULTICYCLE_BNE_EN
        , S_BNE    = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
`ifdef MULTICYCLE_BNE_EN
        logic       branchNe;
`endif
        logic       irWrite;
        logic       regWrite;
        logic       memWrite;
        logic       iorD;
        logic       regDst;
        logic       memtoReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
    } ctrl_t;

    // Moore output table: everything the datapath sees is a function of the state alone.
    function automatic ctrl_t ctrlFor(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = SRCB_FOUR;
                c.aluOp   = ALUOP_ADD;
            end
            S_DECODE: begin
                c.aluSrcB = SRCB_BRIMM;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: c.iorD = 1'b1;
            S_MEMWB: begin
                c.memtoReg = 1'b1;
                c.regWrite = 1'b1;
            end
            S_MEMWRITE: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
            end
            S_EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_SUB;
                c.pcSrc   = PCSRC_OUT;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            S_ADDIWB: c.regWrite = 1'b1;
            S_JUMP: begin
                c.pcSrc   = PCSRC_JUMP;
                c.pcWrite = 1'b1;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNE: begin
                c.aluSrcA  = 1'b1;
                c.aluOp    = ALUOP_SUB;
                c.pcSrc    = PCSRC_OUT;
                c.branchNe = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp and the R-type funct field to the 3-bit ALU control.
module alu_decoder
    import multicycle_pkg::*;
#(
    parameter int OPW = 6
)
(
    input  logic [1:0]     ALUOp,
    input  logic [OPW-1:0] Funct,
    output logic [2:0]     ALUControl
);

    // Unknown funct codes fall back to add so a bad R-type cannot produce an undefined ALU op.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                if (Funct == OPW'(FN_ADD))      ALUControl = ALU_ADD;
                else if (Funct == OPW'(FN_SUB)) ALUControl = ALU_SUB;
                else if (Funct == OPW'(FN_AND)) ALUControl = ALU_AND;
                else if (Funct == OPW'(FN_OR))  ALUControl = ALU_OR;
                else if (Funct == OPW'(FN_SLT)) ALUControl = ALU_SLT;
                else                            ALUControl = ALU_ADD;
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with registered Moore outputs and a combinational PC enable.
// Optional macro MULTICYCLE_BNE_EN adds bne support through the BNE state.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int OPW = 6
)
(
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] Opcode,
    input  logic [OPW-1:0] Funct,
    input  logic           Zero,
    output logic           PCEn,
    output logic           IRWrite,
    output logic           RegWrite,
    output logic           MemWrite,
    output logic           IorD,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUControl,
    output logic [3:0]     State,
    output logic           IllegalOp
);

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_nextState;
    logic   w_illegal;
    logic   w_branchTaken;

    always_comb begin
        w_nextState = S_FETCH;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: w_nextState = S_DECODE;
            S_DECODE: begin
                if (Opcode == OPW'(OP_RTYPE))                             w_nextState = S_EXECUTE;
                else if (Opcode == OPW'(OP_LW) || Opcode == OPW'(OP_SW)) w_nextState = S_MEMADR;
                else if (Opcode == OPW'(OP_BEQ))                          w_nextState = S_BRANCH;
                else if (Opcode == OPW'(OP_ADDI))                         w_nextState = S_ADDIEX;
                else if (Opcode == OPW'(OP_J))                            w_nextState = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                else if (Opcode == OPW'(OP_BNE))                          w_nextState = S_BNE;
`endif
                else                                                      w_illegal   = 1'b1;
            end
            S_MEMADR:  w_nextState = (Opcode == OPW'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_nextState = S_MEMWB;
            S_EXECUTE: w_nextState = S_ALUWB;
            S_ADDIEX:  w_nextState = S_ADDIWB;
            default:   w_nextState = S_FETCH;
        endcase
    end

    // Outputs are loaded alongside the state so they come straight from flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrlFor(S_FETCH);
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= ctrlFor(w_nextState);
        end
    end

`ifdef MULTICYCLE_BNE_EN
    assign w_branchTaken = (r_ctrl.branch & Zero) | (r_ctrl.branchNe & ~Zero);
`else
    assign w_branchTaken = r_ctrl.branch & Zero;
`endif

    // Write enables are masked during reset so nothing is committed before the first FETCH.
    assign PCEn      = ~RST & (r_ctrl.pcWrite | w_branchTaken);
    assign IRWrite   = ~RST & r_ctrl.irWrite;
    assign RegWrite  = ~RST & r_ctrl.regWrite;
    assign MemWrite  = ~RST & r_ctrl.memWrite;
    assign IllegalOp = ~RST & w_illegal;

    assign IorD     = r_ctrl.iorD;
    assign RegDst   = r_ctrl.regDst;
    assign MemtoReg = r_ctrl.memtoReg;
    assign ALUSrcA  = r_ctrl.aluSrcA;
    assign ALUSrcB  = r_ctrl.aluSrcB;
    assign PCSrc    = r_ctrl.pcSrc;
    assign State    = r_state;

    alu_decoder #(
        .OPW(OPW)
    ) u_aluDecoder (
        .ALUOp      (r_ctrl.aluOp),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; expectations follow MULTICYCLE_BNE_EN.
module tb_multicycle_controller;

    logic       CLK;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       IllegalOp;

    int checkCount = 0;
    int errorCount = 0;

    multicycle_controller #(.OPW(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Zero       (Zero),
        .PCEn       (PCEn),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .IllegalOp  (IllegalOp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Opcode = op;
        Funct  = fn;
        Zero   = z;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST    = 1'b1;
        Opcode = 6'b100011;
        Funct  = 6'b000000;
        Zero   = 1'b0;

        // Power-on reset
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("por_state", State, 4'd0);
        checkOutput("por_irwrite", IRWrite, 1'b0);
        checkOutput("por_pcen", PCEn, 1'b0);
        checkOutput("por_regwrite", RegWrite, 1'b0);
        checkOutput("por_memwrite", MemWrite, 1'b0);
        checkOutput("por_illegal", IllegalOp, 1'b0);
        RST = 1'b0;
        #1;
        checkOutput("por_fetch_irwrite", IRWrite, 1'b1);
        checkOutput("por_fetch_pcen", PCEn, 1'b1);

        // lw: 0,1,2,3,4,0
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        checkOutput("lw_s0", State, 4'd0);
        checkOutput("lw_s0_alusrcb", ALUSrcB, 2'b01);
        checkOutput("lw_s0_aluctl", ALUControl, 3'b010);
        checkOutput("lw_s0_regwrite", RegWrite, 1'b0);
        tick;
        checkOutput("lw_s1", State, 4'd1);
        checkOutput("lw_s1_alusrcb", ALUSrcB, 2'b11);
        checkOutput("lw_s1_pcen", PCEn, 1'b0);
        checkOutput("lw_s1_irwrite", IRWrite, 1'b0);
        tick;
        checkOutput("lw_s2", State, 4'd2);
        checkOutput("lw_s2_alusrca", ALUSrcA, 1'b1);
        checkOutput("lw_s2_alusrcb", ALUSrcB, 2'b10);
        tick;
        checkOutput("lw_s3", State, 4'd3);
        checkOutput("lw_s3_iord", IorD, 1'b1);
        checkOutput("lw_s3_regwrite", RegWrite, 1'b0);
        checkOutput("lw_s3_memtoreg", MemtoReg, 1'b0);
        tick;
        checkOutput("lw_s4", State, 4'd4);
        checkOutput("lw_s4_memtoreg", MemtoReg, 1'b1);
        checkOutput("lw_s4_regwrite", RegWrite, 1'b1);
        tick;
        checkOutput("lw_end", State, 4'd0);
        checkOutput("lw_end_regwrite", RegWrite, 1'b0);
        checkOutput("lw_end_memtoreg", MemtoReg, 1'b0);

        // sw: 0,1,2,5,0
        applyStimulus(6'b101011, 6'b000000, 1'b0);
        tick;
        tick;
        checkOutput("sw_s2", State, 4'd2);
        tick;
        checkOutput("sw_s5", State, 4'd5);
        checkOutput("sw_s5_memwrite", MemWrite, 1'b1);
        checkOutput("sw_s5_iord", IorD, 1'b1);
        tick;
        checkOutput("sw_end", State, 4'd0);
        checkOutput("sw_end_memwrite", MemWrite, 1'b0);

        // R-type sub then slt, plus and and an unknown funct
        applyStimulus(6'b000000, 6'b100010, 1'b0);
        tick;
        checkOutput("rsub_s1", State, 4'd1);
        tick;
        checkOutput("rsub_s6", State, 4'd6);
        checkOutput("rsub_aluctl", ALUControl, 3'b110);
        checkOutput("rsub_alusrca", ALUSrcA, 1'b1);
        tick;
        checkOutput("rsub_s7", State, 4'd7);
        checkOutput("rsub_regdst", RegDst, 1'b1);
        checkOutput("rsub_regwrite", RegWrite, 1'b1);
        tick;
        checkOutput("rsub_end", State, 4'd0);
        checkOutput("rsub_end_regdst", RegDst, 1'b0);

        applyStimulus(6'b000000, 6'b101010, 1'b0);
        tick;
        tick;
        checkOutput("rslt_s6", State, 4'd6);
        checkOutput("rslt_aluctl", ALUControl, 3'b111);
        tick;
        checkOutput("rslt_s7_aluctl", ALUControl, 3'b010);
        tick;

        applyStimulus(6'b000000, 6'b100100, 1'b0);
        tick;
        tick;
        checkOutput("rand_aluctl", ALUControl, 3'b000);
        Funct = 6'b100101;
        #1;
        checkOutput("ror_aluctl", ALUControl, 3'b001);
        Funct = 6'b111111;
        #1;
        checkOutput("rbad_aluctl", ALUControl, 3'b010);
        tick;
        tick;
        checkOutput("rand_end", State, 4'd0);

        // beq taken then not taken
        applyStimulus(6'b000100, 6'b000000, 1'b1);
        tick;
        tick;
        checkOutput("beqt_s8", State, 4'd8);
        checkOutput("beqt_pcen", PCEn, 1'b1);
        checkOutput("beqt_pcsrc", PCSrc, 2'b01);
        checkOutput("beqt_aluctl", ALUControl, 3'b110);
        tick;
        checkOutput("beqt_end", State, 4'd0);
        applyStimulus(6'b000100, 6'b000000, 1'b0);
        tick;
        tick;
        checkOutput("beqn_s8", State, 4'd8);
        checkOutput("beqn_pcen", PCEn, 1'b0);
        tick;
        checkOutput("beqn_end", State, 4'd0);

        // addi: 0,1,9,10,0
        applyStimulus(6'b001000, 6'b000000, 1'b0);
        tick;
        tick;
        checkOutput("addi_s9", State, 4'd9);
        checkOutput("addi_s9_alusrcb", ALUSrcB, 2'b10);
        tick;
        checkOutput("addi_s10", State, 4'd10);
        checkOutput("addi_s10_regwrite", RegWrite, 1'b1);
        checkOutput("addi_s10_regdst", RegDst, 1'b0);
        tick;
        checkOutput("addi_end", State, 4'd0);

        // j: 0,1,11,0
        applyStimulus(6'b000010, 6'b000000, 1'b0);
        tick;
        checkOutput("j_s1", State, 4'd1);
        tick;
        checkOutput("j_s11", State, 4'd11);
        checkOutput("j_pcsrc", PCSrc, 2'b10);
        checkOutput("j_pcen", PCEn, 1'b1);
        tick;
        checkOutput("j_end", State, 4'd0);

        // bne: own state when enabled, otherwise illegal
        applyStimulus(6'b000101, 6'b000000, 1'b0);
        tick;
        checkOutput("bne_s1", State, 4'd1);
`ifdef MULTICYCLE_BNE_EN
        checkOutput("bne_s1_illegal", IllegalOp, 1'b0);
        tick;
        checkOutput("bne_s12", State, 4'd12);
        checkOutput("bne_pcen", PCEn, 1'b1);
        checkOutput("bne_pcsrc", PCSrc, 2'b01);
        Zero = 1'b1;
        #1;
        checkOutput("bne_zero_pcen", PCEn, 1'b0);
        tick;
        checkOutput("bne_end", State, 4'd0);
`else
        checkOutput("bne_s1_illegal", IllegalOp, 1'b1);
        tick;
        checkOutput("bne_end", State, 4'd0);
        checkOutput("bne_end_illegal", IllegalOp, 1'b0);
`endif

        // Unsupported opcode
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        checkOutput("ill_s0_illegal", IllegalOp, 1'b0);
        tick;
        checkOutput("ill_s1", State, 4'd1);
        checkOutput("ill_s1_illegal", IllegalOp, 1'b1);
        tick;
        checkOutput("ill_end", State, 4'd0);
        checkOutput("ill_end_illegal", IllegalOp, 1'b0);

        // Reset in the middle of lw (MEMREAD)
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        tick;
        tick;
        tick;
        checkOutput("rst_pre_s3", State, 4'd3);
        RST = 1'b1;
        #1;
        checkOutput("rst_mid_irwrite", IRWrite, 1'b0);
        checkOutput("rst_mid_pcen", PCEn, 1'b0);
        tick;
        checkOutput("rst_e1_state", State, 4'd0);
        checkOutput("rst_e1_irwrite", IRWrite, 1'b0);
        checkOutput("rst_e1_pcen", PCEn, 1'b0);
        checkOutput("rst_e1_regwrite", RegWrite, 1'b0);
        checkOutput("rst_e1_memwrite", MemWrite, 1'b0);
        tick;
        checkOutput("rst_e2_state", State, 4'd0);
        RST = 1'b0;
        #1;
        checkOutput("rst_rel_irwrite", IRWrite, 1'b1);
        checkOutput("rst_rel_pcen", PCEn, 1'b1);
        tick;
        checkOutput("rst_next_state", State, 4'd1);
        checkOutput("rst_next_irwrite", IRWrite, 1'b0);
        checkOutput("rst_next_pcen", PCEn, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter OPW, default 6, giving the opcode and funct field width in bits.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have ports Opcode and Funct, inputs, OPW each, instruction fields [31:26] and [5:0] from the datapath instruction register.
REQ-005 SHALL have port Zero, input, 1, the ALU zero flag.
REQ-006 SHALL have 1-bit outputs PCEn, IRWrite, RegWrite, MemWrite, IorD, RegDst, MemtoReg and ALUSrcA.
REQ-007 SHALL have outputs ALUSrcB (2 bits), PCSrc (2 bits), ALUControl (3 bits) and State (4 bits, current state for debug).
REQ-008 SHALL have output IllegalOp, 1 bit, a one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-009 SHALL be a Moore FSM; all outputs except PCEn and ALUControl SHALL decode from State only.
REQ-010 SHALL use state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12.
REQ-011 SHALL assert these outputs per state; any output not listed is 0:
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00; next state DECODE.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMREAD: IorD=1; next MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWRITE: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALUOp=10; next ALUWB.
- ALUWB: RegDst=1, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10; next ADDIWB.
- ADDIWB: RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-012 SHALL leave DECODE, by Opcode, to: 000000 EXECUTE; 100011 or 101011 MEMADR; 000100 BRANCH; 001000 ADDIEX; 000010 JUMP; 000101 BNE (macro only, see REQ-020); any other opcode FETCH with IllegalOp=1.
REQ-013 SHALL leave MEMADR to MEMREAD for 100011 and to MEMWRITE for 101011.
REQ-014 SHALL return to FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP and BNE.
REQ-015 SHALL drive PCEn = PCWrite | (Branch & Zero) | (BranchNe & ~Zero), combinationally in the same cycle.
REQ-016 SHALL drive ALUControl combinationally:
- ALUOp 00: 010 (add).
- ALUOp 01: 110 (sub).
- ALUOp 10, by Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other Funct→010.
REQ-017 SHALL give cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, illegal 2.

Reset
REQ-018 SHALL load State=FETCH at the first rising edge with RST=1, from any state including mid-instruction, and hold FETCH while RST=1.
REQ-019 SHALL force PCEn, IRWrite, RegWrite, MemWrite and IllegalOp to 0 while RST=1; after reset, the first cycle is FETCH with IRWrite=1 and PCEn=1.

Configuration
REQ-020 SHALL support macro MULTICYCLE_BNE_EN:
- Defined: opcode 000101 goes DECODE→BNE; BNE outputs equal BRANCH except Branch=0 and BranchNe=1.
- Undefined: state BNE and signal BranchNe are absent (BranchNe treated as 0), and 000101 is illegal.

Structure
REQ-021 SHALL place state, opcode, funct and ALUControl encodings as constants in a shared package multicycle_pkg.
REQ-022 SHALL implement REQ-016 in one sub-module, alu_decoder, with inputs ALUOp and Funct and output ALUControl.

Verification
REQ-023 Reset test: RST=1 for 2 edges while in MEMREAD → State=0 and all write enables 0; after RST drops, IRWrite=1 and PCEn=1 for exactly one cycle.
REQ-024 lw test: Opcode=100011 → State sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-025 R-type test: Opcode=000000 with Funct 100010 then 101010 → ALUControl 110 then 111 in EXECUTE; RegDst=1 in ALUWB.
REQ-026 beq test: Opcode=000100 with Zero=1 → PCEn=1 in BRANCH; with Zero=0 → PCEn=0.
REQ-027 bne/illegal test: Opcode=000101 with Zero=0 → PCEn=1 in state 12 when the macro is defined; without the macro → IllegalOp=1 for one cycle and the sequence is 0,1,0.
REQ-028 j test: Opcode=000010 → sequence 0,1,11,0 with PCSrc=10 and PCEn=1 in JUMP.
